rca_sum_accum: RTL and testbench



---
 rtl/rca_sum_accum.sv | 129 ++++++++++++
 tb/tb_rca_sum_accum.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rca_sum_accum.sv
`default_nettype none
// ============================================================================
// Module   : rca_sum_accum
// Brief    : Accumulates FRAME_LEN adder sums into one frame total and
//            presents total, sample count and sticky overflow on a
//            valid/ready output port.
// Revision : 1.0 - initial release
// ============================================================================
module rca_sum_accum #(
    parameter int IN_W      = 11,
    parameter int OUT_W     = 16,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_total,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_FRAME_LEN = CNT_W'(FRAME_LEN);
    localparam int               C_PAD_W     = OUT_W + 1 - IN_W;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_total_q, out_total_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic [OUT_W:0]     sum_w;
    logic [CNT_W-1:0]   cnt_inc_w;
    logic               accept_w;
    logic               close_w;

    assign in_ready  = (state_q == ST_ACC);
    assign accept_w  = in_valid & in_ready;
    assign cnt_inc_w = cnt_q + CNT_W'(1);

    // One extra bit on the add captures the carry-out that feeds the sticky flag.
    assign sum_w = {1'b0, acc_q} + {{C_PAD_W{1'b0}}, in_sum};

    assign close_w = (accept_w && (cnt_inc_w == C_FRAME_LEN))
                   || (flush && (cnt_q != '0 || accept_w));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_total_d = out_total_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            ST_ACC: begin
                if (accept_w) begin
                    acc_d = sum_w[OUT_W-1:0];
                    cnt_d = cnt_inc_w;
                    ovf_d = ovf_q | sum_w[OUT_W];
                end
                if (close_w) begin
                    state_d     = ST_HOLD;
                    out_valid_d = 1'b1;
                    out_total_d = acc_d;
                    out_count_d = cnt_d;
                    out_ovf_d   = ovf_d;
                end
            end
            ST_HOLD: begin
                // Result fields stay put after the handshake; only valid drops.
                if (out_ready) begin
                    state_d     = ST_ACC;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_total_q <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_total_q <= out_total_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_total = out_total_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rca_sum_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca_sum_accum
// Brief    : Directed table-driven bench for rca_sum_accum (default and
//            narrow-total overflow configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rca_sum_accum;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] in_sum = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_total;
    logic [2:0]  out_count;
    logic        out_ovf;

    logic        n_in_valid = 1'b0;
    logic        n_in_ready;
    logic [10:0] n_in_sum = '0;
    logic        n_flush = 1'b0;
    logic        n_out_valid;
    logic        n_out_ready = 1'b0;
    logic [9:0]  n_out_total;
    logic [1:0]  n_out_count;
    logic        n_out_ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rca_sum_accum dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_total (out_total),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    rca_sum_accum #(.IN_W(11), .OUT_W(10), .FRAME_LEN(2)) dut_n (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .in_sum    (n_in_sum),
        .flush     (n_flush),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .out_total (n_out_total),
        .out_count (n_out_count),
        .out_ovf   (n_out_ovf)
    );

    typedef struct {
        logic        iv;
        logic [10:0] s;
        logic        fl;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [15:0] e_tot;
        logic [2:0]  e_cnt;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic iv, input int s, input logic fl, input logic ordy,
                       input logic e_ir, input logic e_ov, input int e_tot,
                       input int e_cnt, input logic e_ovf);
        vec_t v;
        v.iv = iv; v.s = 11'(s); v.fl = fl; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_tot = 16'(e_tot);
        v.e_cnt = 3'(e_cnt); v.e_ovf = e_ovf;
        vecs.push_back(v);
    endtask

    task automatic drv(input logic iv, input int s, input logic fl, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_sum    = 11'(s);
        flush     = fl;
        out_ready = ordy;
        #1;
    endtask

    task automatic drv_n(input logic iv, input int s, input logic ordy);
        @(negedge clk);
        n_in_valid  = iv;
        n_in_sum    = 11'(s);
        n_out_ready = ordy;
        #1;
    endtask

    task automatic chk_out(input string nm, input logic ir, input logic ov,
                           input int tot, input int cnt, input logic ovf);
        chk({nm, ".in_ready"},  32'(in_ready),  32'(ir));
        chk({nm, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({nm, ".out_total"}, 32'(out_total), 32'(tot));
        chk({nm, ".out_count"}, 32'(out_count), 32'(cnt));
        chk({nm, ".out_ovf"},   32'(out_ovf),   32'(ovf));
    endtask

    task automatic chk_n(input string nm, input logic ov, input int tot,
                         input int cnt, input logic ovf);
        chk({nm, ".out_valid"}, 32'(n_out_valid), 32'(ov));
        chk({nm, ".out_total"}, 32'(n_out_total), 32'(tot));
        chk({nm, ".out_count"}, 32'(n_out_count), 32'(cnt));
        chk({nm, ".out_ovf"},   32'(n_out_ovf),   32'(ovf));
    endtask

    initial begin
        // Row: inputs for the cycle, then outputs expected during that cycle.
        //   iv  sum  fl or | ir ov  tot  cnt ovf
        add(1,   6,   0, 1,   1, 0,    0, 0, 0);   // full frame 6,256,765,0
        add(1, 256,   0, 1,   1, 0,    0, 0, 0);
        add(1, 765,   0, 1,   1, 0,    0, 0, 0);
        add(1,   0,   0, 1,   1, 0,    0, 0, 0);
        add(0,   0,   0, 1,   0, 1, 1027, 4, 0);   // HOLD, handshake
        add(0,   0,   0, 1,   1, 0, 1027, 4, 0);   // bubble over, fields retained
        add(1, 765,   0, 1,   1, 0, 1027, 4, 0);   // partial: 765, 235+flush
        add(1, 235,   1, 1,   1, 0, 1027, 4, 0);
        add(0,   0,   0, 1,   0, 1, 1000, 2, 0);
        add(0,   0,   1, 1,   1, 0, 1000, 2, 0);   // flush on empty frame
        add(0,   0,   0, 1,   1, 0, 1000, 2, 0);
        add(1,  10,   0, 0,   1, 0, 1000, 2, 0);   // flush without accept
        add(0,   0,   1, 0,   1, 0, 1000, 2, 0);
        add(0,   0,   0, 0,   0, 1,   10, 1, 0);
        add(0,   0,   1, 1,   0, 1,   10, 1, 0);   // flush in HOLD ignored
        add(0,   0,   0, 0,   1, 0,   10, 1, 0);
        add(1,   1,   0, 0,   1, 0,   10, 1, 0);   // backpressure frame 1..4
        add(1,   2,   0, 0,   1, 0,   10, 1, 0);
        add(1,   3,   0, 0,   1, 0,   10, 1, 0);
        add(1,   4,   0, 0,   1, 0,   10, 1, 0);
        for (int i = 0; i < 5; i++)
            add(1, 99, 0, 0,  0, 1,   10, 4, 0);   // stalled, 99 offered
        add(1,  99,   0, 1,   0, 1,   10, 4, 0);
        add(1,  99,   0, 1,   1, 0,   10, 4, 0);   // 99 opens next frame
        add(1,   1,   0, 1,   1, 0,   10, 4, 0);
        add(1,   1,   0, 1,   1, 0,   10, 4, 0);
        add(1,   1,   0, 1,   1, 0,   10, 4, 0);
        add(0,   0,   0, 1,   0, 1,  102, 4, 0);
        add(0,   0,   0, 1,   1, 0,  102, 4, 0);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_out("reset", 1, 0, 0, 0, 0);
        chk_n("reset_n", 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drv(vecs[i].iv, int'(vecs[i].s), vecs[i].fl, vecs[i].ordy);
            chk_out($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov,
                    int'(vecs[i].e_tot), int'(vecs[i].e_cnt), vecs[i].e_ovf);
        end

        // Overflow on the 10-bit instance: 765+765 wraps to 506.
        drv_n(1, 765, 0);
        drv_n(1, 765, 0);
        drv_n(0, 0, 0);
        chk_n("ovf_hold", 1, 506, 2, 1);
        drv_n(0, 0, 1);
        chk_n("ovf_hs", 1, 506, 2, 1);
        drv_n(1, 1, 1);
        chk("ovf_ready", 32'(n_in_ready), 1);
        drv_n(1, 2, 1);
        drv_n(0, 0, 1);
        chk_n("ovf_next", 1, 3, 2, 0);
        drv_n(0, 0, 1);
        chk("ovf_drop", 32'(n_out_valid), 0);

        // Reset mid-frame discards the partial sum.
        drv(1, 100, 0, 0);
        drv(1, 200, 0, 0);
        drv(0, 0, 0, 0);
        chk("mid_no_valid", 32'(out_valid), 0);
        @(negedge clk); reset = 1'b1; #1;
        @(negedge clk); reset = 1'b0; #1;
        chk_out("mid_reset", 1, 0, 0, 0, 0);
        drv(1, 5, 0, 0);
        drv(1, 6, 0, 0);
        drv(1, 7, 0, 0);
        chk("mid_no_early", 32'(out_valid), 0);
        drv(1, 8, 0, 0);
        drv(0, 0, 0, 0);
        chk_out("mid_after", 0, 1, 26, 4, 0);

        // Reset during HOLD with out_ready low.
        drv(0, 0, 0, 0);
        chk("hold_pre", 32'(out_valid), 1);
        @(negedge clk); reset = 1'b1; #1;
        @(negedge clk); reset = 1'b0; #1;
        chk_out("hold_reset", 1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
